prbs_checker_galois: RTL

//  Receive-side checker for the Galois LFSR pattern generator. Samples a

---
 rtl/prbs_checker_galois.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/prbs_checker_galois.sv
// ---------------------------------------------------------------------------
// prbs_checker_galois
//
// Receive-side checker for a Galois LFSR pattern generator. It watches a
// parallel word stream and self-synchronises to the LFSR sequence by checking
// that consecutive words follow the step function. Once it has seen enough
// consecutive good steps, it tracks the stream with a free-running reference.
// While locked it counts word errors and bit errors, and it drops lock after
// a run of consecutive mismatching words.
//
// Step function: nxt(q) = (q >> 1) ^ (q[0] ? POLY : 0)
//
// Ports
//   clk_i          clock
//   rst_n_i        synchronous reset, active-low
//   vld_i          dat_i carries a valid sample this cycle
//   dat_i          received word
//   clr_i          synchronous clear of both error counters
//   lock_o         checker is in the LOCKED state
//   err_o          1-cycle pulse: previous valid word mismatched while LOCKED
//   err_cnt_o      mismatching words seen while LOCKED (saturating)
//   bit_err_cnt_o  mismatching bits seen while LOCKED (saturating)
// ---------------------------------------------------------------------------
module prbs_checker_galois #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] POLY       = 32'h8020_0003,
  parameter int                    LOCK_CNT   = 4,
  parameter int                    LOSS_CNT   = 4,
  parameter int                    CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  vld_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic                  clr_i,
  output logic                  lock_o,
  output logic                  err_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o,
  output logic [CNT_WIDTH-1:0]  bit_err_cnt_o
);

  // Width of a popcount over one data word.
  localparam int PW = $clog2(DATA_WIDTH + 1);
  // Widths of the lock / loss run-length counters.
  localparam int MW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;
  localparam int LW = (LOSS_CNT > 1) ? $clog2(LOSS_CNT + 1) : 1;
  // Width used for the saturating bit-error addition: wide enough to hold
  // either operand plus a carry, so an overflow can be detected rather than
  // silently wrapping.
  localparam int SW = ((CNT_WIDTH > PW) ? CNT_WIDTH : PW) + 1;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [LW-1:0] MISS_LAST  = LW'(LOSS_CNT - 1);

  // Checker states.
  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  function automatic logic [DATA_WIDTH-1:0] nxt(input logic [DATA_WIDTH-1:0] q);
    nxt = (q >> 1) ^ (q[0] ? POLY : '0);
  endfunction

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  logic [0:0]            state_reg,     state_next;
  logic [DATA_WIDTH-1:0] prev_reg,      prev_next;
  logic                  have_prev_reg, have_prev_next;
  logic [MW-1:0]         match_reg,     match_next;
  logic [LW-1:0]         miss_reg,      miss_next;
  logic [DATA_WIDTH-1:0] ref_reg,       ref_next;
  logic                  err_reg,       err_next;
  logic [CNT_WIDTH-1:0]  err_cnt_reg,   err_cnt_next;
  logic [CNT_WIDTH-1:0]  bit_cnt_reg,   bit_cnt_next;

  // -------------------------------------------------------------------------
  // Datapath: comparison against the expected word and error popcount
  // -------------------------------------------------------------------------
  logic                  seq_hit;     // dat_i is a valid next step of prev (acquisition)
  logic [DATA_WIDTH-1:0] diff;        // bitwise difference against the reference
  logic                  ref_miss;    // dat_i differs from the reference
  logic [PW-1:0]         diff_pop;    // number of differing bits
  logic [SW-1:0]         bit_sum;     // widened bit-counter sum for saturation
  logic [CNT_WIDTH-1:0]  err_cnt_inc; // saturating word-error increment
  logic [CNT_WIDTH-1:0]  bit_cnt_add; // saturating bit-error accumulation

  // An all-zero word is the LFSR lock-up state, so it never counts as a
  // sequence step even though nxt(0) == 0.
  assign seq_hit  = have_prev_reg && (dat_i != '0) && (dat_i == nxt(prev_reg));
  assign diff     = dat_i ^ ref_reg;
  assign ref_miss = (diff != '0);

  // Popcount as a running sum over per-bit terms.
  logic [PW-1:0] pop_acc [DATA_WIDTH+1];
  assign pop_acc[0] = '0;
  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_pop
      assign pop_acc[gi+1] = pop_acc[gi] + PW'(diff[gi]);
    end
  endgenerate
  assign diff_pop = pop_acc[DATA_WIDTH];

  assign err_cnt_inc = (err_cnt_reg == CNT_MAX) ? CNT_MAX
                                                : err_cnt_reg + CNT_WIDTH'(1);
  assign bit_sum     = SW'(bit_cnt_reg) + SW'(diff_pop);
  assign bit_cnt_add = (bit_sum > SW'(CNT_MAX)) ? CNT_MAX
                                                : bit_sum[CNT_WIDTH-1:0];

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    prev_next      = prev_reg;
    have_prev_next = have_prev_reg;
    match_next     = match_reg;
    miss_next      = miss_reg;
    ref_next       = ref_reg;
    err_next       = 1'b0;
    err_cnt_next   = err_cnt_reg;
    bit_cnt_next   = bit_cnt_reg;

    if (vld_i) begin
      case (state_reg)
        ST_UNLOCKED: begin
          prev_next      = dat_i;
          have_prev_next = 1'b1;
          if (seq_hit && (match_reg == MATCH_LAST)) begin
            // Enough consecutive steps seen; start the free-running
            // reference at the word expected after this one.
            state_next = ST_LOCKED;
            ref_next   = nxt(dat_i);
            miss_next  = '0;
            match_next = '0;
          end else if (seq_hit) begin
            match_next = match_reg + MW'(1);
          end else begin
            match_next = '0;
          end
        end

        ST_LOCKED: begin
          // The reference always advances, so one corrupted word costs
          // exactly one error instead of derailing the comparison.
          ref_next = nxt(ref_reg);
          if (!ref_miss) begin
            miss_next = '0;
          end else begin
            err_next     = 1'b1;
            err_cnt_next = err_cnt_inc;
            bit_cnt_next = bit_cnt_add;
            if (miss_reg == MISS_LAST) begin
              // Sustained mismatch: restart acquisition, seeding it with
              // the current word so the next word can already be a step.
              state_next     = ST_UNLOCKED;
              match_next     = '0;
              miss_next      = '0;
              prev_next      = dat_i;
              have_prev_next = 1'b1;
            end else begin
              miss_next = miss_reg + LW'(1);
            end
          end
        end

        default: begin
          state_next = ST_UNLOCKED;
        end
      endcase
    end

    // Clear wins over a coincident error; err_o still reports it.
    if (clr_i) begin
      err_cnt_next = '0;
      bit_cnt_next = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_reg     <= ST_UNLOCKED;
      prev_reg      <= '0;
      have_prev_reg <= 1'b0;
      match_reg     <= '0;
      miss_reg      <= '0;
      ref_reg       <= '0;
      err_reg       <= 1'b0;
      err_cnt_reg   <= '0;
      bit_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      prev_reg      <= prev_next;
      have_prev_reg <= have_prev_next;
      match_reg     <= match_next;
      miss_reg      <= miss_next;
      ref_reg       <= ref_next;
      err_reg       <= err_next;
      err_cnt_reg   <= err_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
    end
  end

  // lock_o is a direct decode of the state register, so it changes in the
  // same cycle as the state.
  assign lock_o        = (state_reg == ST_LOCKED);
  assign err_o         = err_reg;
  assign err_cnt_o     = err_cnt_reg;
  assign bit_err_cnt_o = bit_cnt_reg;

endmodule
